// File: rtl/logip_pkg.sv
// Shared definitions for the capture path: sample word size and the
// sample_store controller states.
package logip_pkg;

  localparam int SAMPLE_BYTES = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_POST,
    ST_RD_REQ,
    ST_RD_OUT
  } store_state_t;

endpackage

// File: rtl/ram_sdp.sv
// Simple dual-port RAM: one write port, one registered read port with a
// single cycle of latency. Contents are never reset.
module ram_sdp #(
  parameter int DW    = 32,
  parameter int DEPTH = 1024
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [DW-1:0]            i_wdata,
  input  logic                     i_re,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [DW-1:0]            o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sample_store.sv
// Ring-buffer capture: writes while armed, stops a programmable number of
// words after the trigger, then streams the buffer back newest-first.
module sample_store
  import logip_pkg::*;
#(
  parameter int WIDTH = SAMPLE_BYTES,
  parameter int DEPTH = 1024
) (
  input  logic               clk_i,
  input  logic               rst_in,
  input  logic               arm_i,
  input  logic               abort_i,
  input  logic               trg_i,
  input  logic [15:0]        delay_i,
  input  logic [15:0]        read_cnt_i,
  input  logic               stb_i,
  input  logic [WIDTH*8-1:0] d_i,
  output logic               stb_o,
  output logic [WIDTH*8-1:0] q_o,
  input  logic               rdy_i,
  output logic               armed_o,
  output logic               done_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = WIDTH * 8;
  localparam logic [15:0] DEPTH16 = 16'(DEPTH);

  store_state_t r_state, w_state_nxt;

  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [15:0]   r_delay, r_rcnt, r_post_cnt, r_rd_left;
  logic          r_done;

  logic          w_we, w_re, w_enter_rd, w_done_set, w_hs, w_arm, w_trg;
  logic [DW-1:0] w_rdata;

  // Next-state logic; abort overrides everything, and any path into
  // readback with nothing to read finishes straight away.
  always_comb begin
    w_state_nxt = r_state;
    w_enter_rd  = 1'b0;
    w_done_set  = 1'b0;
    w_we        = stb_i && !abort_i && (r_state == ST_ARMED || r_state == ST_POST);
    w_re        = (r_state == ST_RD_REQ);
    w_hs        = (r_state == ST_RD_OUT) && rdy_i;
    w_arm       = (r_state == ST_IDLE) && arm_i && !abort_i;
    w_trg       = (r_state == ST_ARMED) && trg_i && !abort_i;
    if (abort_i) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   if (arm_i) w_state_nxt = ST_ARMED;
        ST_ARMED: begin
          if (trg_i) begin
            if (r_delay == 16'd0) w_enter_rd = 1'b1;
            else                  w_state_nxt = ST_POST;
          end
        end
        ST_POST:   if (stb_i && r_post_cnt == 16'd1) w_enter_rd = 1'b1;
        ST_RD_REQ: w_state_nxt = ST_RD_OUT;
        ST_RD_OUT: begin
          if (rdy_i) begin
            if (r_rd_left == 16'd1) begin
              w_state_nxt = ST_IDLE;
              w_done_set  = 1'b1;
            end else begin
              w_state_nxt = ST_RD_REQ;
            end
          end
        end
        default:   w_state_nxt = ST_IDLE;
      endcase
      if (w_enter_rd) begin
        if (r_rcnt == 16'd0) begin
          w_state_nxt = ST_IDLE;
          w_done_set  = 1'b1;
        end else begin
          w_state_nxt = ST_RD_REQ;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      r_state    <= ST_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_delay    <= '0;
      r_rcnt     <= '0;
      r_post_cnt <= '0;
      r_rd_left  <= '0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_set;
      if (w_arm) begin
        r_delay <= delay_i;
        r_rcnt  <= (read_cnt_i > DEPTH16) ? DEPTH16 : read_cnt_i;
      end
      if (w_we) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_trg)
        r_post_cnt <= r_delay;
      else if (r_state == ST_POST && w_we)
        r_post_cnt <= r_post_cnt - 16'd1;
      // Newest word is the one just below the write pointer after this edge.
      if (w_enter_rd) begin
        r_rd_ptr  <= w_we ? r_wr_ptr : r_wr_ptr - 1'b1;
        r_rd_left <= r_rcnt;
      end else if (w_hs) begin
        r_rd_ptr  <= r_rd_ptr - 1'b1;
        r_rd_left <= r_rd_left - 16'd1;
      end
    end
  end

  ram_sdp #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_ram (
    .i_clk   (clk_i),
    .i_we    (w_we),
    .i_waddr (r_wr_ptr),
    .i_wdata (d_i),
    .i_re    (w_re),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_rdata)
  );

  assign stb_o   = (r_state == ST_RD_OUT);
  assign q_o     = stb_o ? w_rdata : '0;
  assign armed_o = (r_state == ST_ARMED) || (r_state == ST_POST);
  assign done_o  = r_done;

endmodule

// File: tb/tb_sample_store.sv
// Scoreboard bench for sample_store with DEPTH=16, WIDTH=4: directed capture
// scenarios push expected readback words, a monitor pops on each handshake.
module tb_sample_store;

  logic        clk_i = 1'b0;
  logic        rst_in = 1'b0;
  logic        arm_i = 1'b0, abort_i = 1'b0, trg_i = 1'b0, stb_i = 1'b0;
  logic [15:0] delay_i = '0, read_cnt_i = '0;
  logic [31:0] d_i = '0;
  logic        rdy_i = 1'b1;
  logic        stb_o, armed_o, done_o;
  logic [31:0] q_o;

  int          checks = 0, errors = 0;
  int          doneSeen = 0, stbSeen = 0;
  int          rdyMode = 0, rdyPhase = 0;
  logic [31:0] expQ[$];
  logic        prevStall = 1'b0;
  logic [31:0] prevQ = '0;

  sample_store #(.WIDTH(4), .DEPTH(16)) dut (
    .clk_i(clk_i), .rst_in(rst_in), .arm_i(arm_i), .abort_i(abort_i),
    .trg_i(trg_i), .delay_i(delay_i), .read_cnt_i(read_cnt_i),
    .stb_i(stb_i), .d_i(d_i), .stb_o(stb_o), .q_o(q_o), .rdy_i(rdy_i),
    .armed_o(armed_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus, driven just after the rising edge.
  task automatic applyStimulus(input logic arm, input logic trg, input logic stb,
                               input logic abort, input logic [31:0] d);
    @(posedge clk_i);
    #1;
    arm_i = arm; trg_i = trg; stb_i = stb; abort_i = abort; d_i = d;
  endtask

  task automatic waitDone(input int target, input bit junk, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (doneSeen >= target) break;
      applyStimulus(0, 0, junk, 0, 32'hDEAD_0000 + i);
    end
    checkOutput("done count", doneSeen, target);
    checkOutput("queue drained", expQ.size(), 0);
  endtask

  task automatic pushRange(input logic [31:0] first, input int n);
    for (int i = 0; i < n; i++) expQ.push_back(first - i);
  endtask

  always @(posedge clk_i) begin
    #1;
    case (rdyMode)
      0: rdy_i = 1'b1;
      1: begin
        rdy_i = (rdyPhase == 0);
        rdyPhase = (rdyPhase + 1) % 4;
      end
      default: rdy_i = 1'b0;
    endcase
  end

  // Monitor: compare each accepted word, check stall stability, count pulses.
  always @(negedge clk_i) begin
    if (rst_in) begin
      if (stb_o) begin
        stbSeen++;
        if (prevStall) checkOutput("stall hold", q_o, prevQ);
        if (rdy_i) begin
          if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL extra word: got 0x%0h, expected none", q_o);
          end else begin
            checkOutput("readback", q_o, expQ.pop_front());
          end
        end
      end
      if (done_o) doneSeen++;
      prevStall = stb_o && !rdy_i;
      prevQ = q_o;
    end else begin
      prevStall = 1'b0;
    end
  end

  initial begin
    int doneRef, stbRef;

    #12;
    checkOutput("reset stb_o", stb_o, 0);
    checkOutput("reset q_o", q_o, 0);
    checkOutput("reset armed_o", armed_o, 0);
    checkOutput("reset done_o", done_o, 0);
    @(negedge clk_i);
    rst_in = 1'b1;

    $display("[TB] basic capture");
    delay_i = 16'd4; read_cnt_i = 16'd8;
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 0, 1, 0, 32'h100 + i);
      if (i == 0) checkOutput("armed rises", armed_o, 1);
    end
    applyStimulus(0, 1, 0, 0, 0);
    pushRange(32'h117, 8);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 0, 32'h114 + i);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("rd_req armed low", armed_o, 0);
    waitDone(1, 0, 60);

    $display("[TB] dropped and ignored inputs");
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 32'hBAD0 + i);
    delay_i = 16'd3; read_cnt_i = 16'd7;
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 32'h200);
    applyStimulus(0, 0, 1, 0, 32'h201);
    applyStimulus(0, 1, 0, 0, 0);
    expQ.push_back(32'h204); expQ.push_back(32'h203); expQ.push_back(32'h202);
    expQ.push_back(32'h201); expQ.push_back(32'h200);
    expQ.push_back(32'h117); expQ.push_back(32'h116);
    applyStimulus(0, 0, 1, 0, 32'h202);
    applyStimulus(0, 1, 1, 0, 32'h203);
    applyStimulus(0, 0, 1, 0, 32'h204);
    waitDone(2, 1, 60);

    $display("[TB] backpressure");
    rdyMode = 1;
    delay_i = 16'd2; read_cnt_i = 16'd5;
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 0, 32'h300 + i);
    applyStimulus(0, 1, 0, 0, 0);
    pushRange(32'h305, 5);
    applyStimulus(0, 0, 1, 0, 32'h304);
    applyStimulus(0, 0, 1, 0, 32'h305);
    waitDone(3, 0, 120);
    repeat (6) applyStimulus(0, 0, 0, 0, 0);
    checkOutput("single done", doneSeen, 3);
    rdyMode = 0;

    $display("[TB] wrap and clamp");
    delay_i = 16'd0; read_cnt_i = 16'd100;
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 40; i++) applyStimulus(0, 0, 1, 0, i);
    applyStimulus(0, 1, 0, 0, 0);
    pushRange(32'h27, 16);
    waitDone(4, 0, 120);

    $display("[TB] abort and re-arm");
    delay_i = 16'd5; read_cnt_i = 16'd4;
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 0, 32'h400 + i);
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 32'h404);
    applyStimulus(0, 0, 1, 0, 32'h405);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("post armed", armed_o, 1);
    applyStimulus(0, 0, 1, 1, 32'h4FF);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("abort armed", armed_o, 0);
    repeat (5) applyStimulus(0, 0, 0, 0, 0);
    checkOutput("abort no done", doneSeen, 4);
    delay_i = 16'd2; read_cnt_i = 16'd6;
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 32'h500);
    applyStimulus(0, 0, 1, 0, 32'h501);
    applyStimulus(0, 1, 0, 0, 0);
    expQ.push_back(32'h503); expQ.push_back(32'h502); expQ.push_back(32'h501);
    expQ.push_back(32'h500); expQ.push_back(32'h405); expQ.push_back(32'h404);
    applyStimulus(0, 0, 1, 0, 32'h502);
    applyStimulus(0, 0, 1, 0, 32'h503);
    waitDone(5, 0, 60);

    $display("[TB] zero readback");
    stbRef = stbSeen;
    delay_i = 16'd1; read_cnt_i = 16'd0;
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 32'h600);
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 32'h601);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("zero done pulse", done_o, 1);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("zero done width", done_o, 0);
    repeat (4) applyStimulus(0, 0, 0, 0, 0);
    checkOutput("zero no stb", stbSeen, stbRef);
    checkOutput("zero done count", doneSeen, 6);

    $display("[TB] reset during readback");
    rdyMode = 2;
    delay_i = 16'd1; read_cnt_i = 16'd4;
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 32'h700);
    applyStimulus(0, 1, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 32'h701);
    for (int i = 0; i < 10; i++) begin
      if (stb_o) break;
      applyStimulus(0, 0, 0, 0, 0);
    end
    checkOutput("rd_out reached", stb_o, 1);
    doneRef = doneSeen;
    #2 rst_in = 1'b0;
    #1;
    checkOutput("async stb_o", stb_o, 0);
    checkOutput("async q_o", q_o, 0);
    checkOutput("async armed_o", armed_o, 0);
    checkOutput("async done_o", done_o, 0);
    @(negedge clk_i);
    rst_in = 1'b1;
    rdyMode = 0;
    repeat (3) applyStimulus(0, 0, 0, 0, 0);
    checkOutput("reset no done", doneSeen, doneRef);
    checkOutput("reset idle stb", stb_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sample_store.md
# sample_store

Capture memory stage directly downstream of the byte-packing cache: it accepts packed sample words on a strobe and writes them continuously into a circular buffer while armed. On trigger it records a programmable number of post-trigger words, then stops. It then reads the buffer back newest-first over a valid/ready handshake toward the transmitter.

## Interface
Parameters
- `WIDTH`, 4: bytes per sample word; must match the upstream packer's `OUTPUT`.
- `DEPTH`, 1024: words in the ring buffer; power of two, ≥ 4.

Ports
- `clk_i` in 1: system clock.
- `rst_in` in 1: reset, asynchronous assert, active-low.
- `arm_i` in 1: pulse; latch `delay_i`/`read_cnt_i` and start capture.
- `abort_i` in 1: pulse; return to IDLE from any state.
- `trg_i` in 1: trigger event, sampled only in ARMED.
- `delay_i` in 16: post-trigger word count.
- `read_cnt_i` in 16: words to read back.
- `stb_i` in 1: `d_i` valid this cycle, from the packer's `stb_o`.
- `d_i` in WIDTH*8: packed sample word.
- `stb_o` out 1: `q_o` valid.
- `q_o` out WIDTH*8: readback word.
- `rdy_i` in 1: consumer accepts `q_o` when `stb_o && rdy_i`.
- `armed_o` out 1: high in ARMED or POST.
- `done_o` out 1: one-cycle pulse when readback completes.

## Operation
- States: IDLE, ARMED, POST, RD_REQ, RD_OUT. The state enum lives in the shared package.
- IDLE + `arm_i`:
  - latch `delay` and `rcnt = min(read_cnt_i, DEPTH)`;
  - `wr_ptr` is kept (not cleared);
  - go to ARMED.
- ARMED: each `stb_i` writes `d_i` at `wr_ptr`, then `wr_ptr++` mod DEPTH.
- ARMED + `trg_i`:
  - load `post_cnt = delay`;
  - go to POST, or to RD_REQ if `delay == 0`;
  - a `stb_i` in the trigger cycle is still written and counted as a pre-trigger word.
- POST:
  - each `stb_i` writes and decrements `post_cnt`;
  - the write that takes `post_cnt` to 0 is the last one, and the FSM goes to RD_REQ next;
  - `trg_i` is ignored.
- Entry to RD_REQ:
  - `rd_ptr = wr_ptr - 1` mod DEPTH (newest word);
  - `rd_left = rcnt`;
  - if `rcnt == 0`, pulse `done_o` and go to IDLE.
- RD_REQ: issue RAM read at `rd_ptr`, then go to RD_OUT.
- RD_OUT:
  - `stb_o = 1`, with `q_o` held stable until `rdy_i`;
  - on handshake: `rd_ptr--` mod DEPTH and `rd_left--`;
  - if `rd_left` reaches 0, pulse `done_o` and go to IDLE; otherwise go to RD_REQ.
- `stb_i` outside ARMED/POST is dropped and causes no write.
- `abort_i` has priority over every other transition:
  - next state IDLE, `stb_o` low;
  - no `done_o` pulse;
  - a write present in the same cycle is suppressed.
- RAM is not reset. Locations never written read back unspecified data.
- Counters are 16 bit. Pointers are `$clog2(DEPTH)` bit and wrap silently in both directions.

## Timing
- Reset values:
  - state IDLE;
  - `stb_o`, `done_o`, `armed_o` all 0;
  - `q_o` 0;
  - `wr_ptr`, `rd_ptr`, `post_cnt`, `rd_left` all 0.
- Write latency: word is stored at the clock edge of its `stb_i` cycle; full throughput, one word per cycle.
- `armed_o` is registered and rises the cycle after `arm_i`.
- Trigger to readback: the last POST write edge is followed by 1 cycle in RD_REQ; `stb_o` is high 2 cycles after that edge.
- RAM read latency is 1 cycle. Readback throughput is at most one word per 2 cycles.
- `q_o` is registered and does not change while `stb_o && !rdy_i`.
- `done_o` is asserted in the cycle after the final handshake, coincident with the return to IDLE.
- Reset asserted mid-operation: all outputs drop immediately (asynchronous); RAM contents are retained.

## Structure
- `logip_pkg` holds:
  - the `store_state_t` enum;
  - a `SAMPLE_BYTES` default shared with the packer.
- Sub-module `ram_sdp`:
  - simple dual-port RAM: one write port, one read port;
  - registered read, 1-cycle latency;
  - no reset;
  - parameters: data width and depth.
- The FSM, pointers and counters stay in `sample_store`.

## Test plan
All scenarios use `DEPTH=16`, `WIDTH=4`.
- Basic capture:
  - stimulus: arm, 20 words 0x100..0x113, trigger after the 20th, `delay=4` with words 0x114..0x117, `read_cnt=8`, `rdy_i=1`;
  - response: `q_o` sequence 0x117, 0x116, …, 0x110, then `done_o` pulse.
- Wrap and clamp:
  - stimulus: arm, 40 words 0x00..0x27, `delay=0` trigger after the last word, `read_cnt=100`;
  - response: exactly 16 words, 0x27 down to 0x18.
- Backpressure:
  - stimulus: `rdy_i` toggles 1-cycle high / 3-cycle low;
  - response: `q_o` stable while stalled, no word duplicated or lost, `done_o` pulses once.
- Dropped and ignored inputs:
  - stimulus: `stb_i` during IDLE and RD_OUT; a second `trg_i` during POST;
  - response: the readback sequence is unaffected; POST length is still exactly `delay`.
- Abort and reset:
  - stimulus: `abort_i` in POST; then re-arm; separately, assert `rst_in` during RD_OUT;
  - response after abort: IDLE, no `done_o`; re-arm captures normally;
  - response after reset: `stb_o` drops immediately (asynchronous), all outputs 0.
- Zero readback:
  - stimulus: `read_cnt=0`;
  - response: `done_o` pulses 1 cycle after the last POST write, `stb_o` never asserted.
